// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu -- RISC-V load/store unit (single outstanding access)
//
// Turns a core load/store request into a one-cycle memory request. It then
// waits in WAIT until mem_ready_i is high. Read data is lane-selected and
// sign- or zero-extended on its way back to the core.
//
// Optional feature (compile-time macro):
//   LSU_MISALIGN_EN -- when defined, a misaligned half/word access is
//                      refused in IDLE. It is flagged on misalign_o for one
//                      cycle, and no memory request is issued.
//                      When undefined, misalign_o is tied low, and misaligned
//                      accesses use the aligned lane.
//
// Ports:
//   clk_i         system clock (rising edge)
//   rst_ni        asynchronous active-low reset
//   core_req_i    core load/store request
//   core_we_i     1 = store, 0 = load
//   core_size_i   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   core_addr_i   byte address
//   core_wd_i     store data, right-aligned
//   core_rd_o     load result, extended to 32 bits
//   core_stall_o  core must hold PC and core_* inputs while high
//   misalign_o    one-cycle misaligned-access flag
//   mem_req_o     memory request
//   mem_we_o      memory write enable
//   mem_be_o      memory byte enables
//   mem_addr_o    memory byte address (pass-through of core_addr_i)
//   mem_wd_o      lane-replicated write data
//   mem_rd_i      memory read data (valid in the cycle after the request)
//   mem_ready_i   memory ready
// -----------------------------------------------------------------------------
module riscv_lsu (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [2:0]  r_size;
   logic [1:0]  r_off;
   logic        r_we;
   logic [31:0] r_rd;

   logic        w_is_byte;
   logic        w_is_half;
   logic        w_misalign;
   logic        w_req;
   logic        w_stall;
   logic        w_mis_flag;
   logic [3:0]  w_be;
   logic [31:0] w_wd;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_val;

   // Size decode: the low two bits give the width, and bit 2 selects unsigned.
   // Any code that is neither byte nor half is handled as a word.
   assign w_is_byte = (core_size_i[1:0] == 2'b00);
   assign w_is_half = (core_size_i[1:0] == 2'b01);

`ifdef LSU_MISALIGN_EN
   assign w_misalign = (w_is_half & core_addr_i[0]) |
                       (!w_is_byte & !w_is_half & (core_addr_i[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   // Byte enables and write data are lane-aligned. A misaligned half or word
   // falls back to its aligned lane.
   always_comb begin
      w_be = 4'b1111;
      w_wd = core_wd_i;
      if (w_is_byte) begin
         w_be = 4'b0001 << core_addr_i[1:0];
         w_wd = {4{core_wd_i[7:0]}};
      end else if (w_is_half) begin
         w_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
         w_wd = {2{core_wd_i[15:0]}};
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_stall      = 1'b0;
      w_mis_flag   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (core_req_i) begin
               if (w_misalign) begin
                  w_mis_flag = 1'b1;
               end else begin
                  w_req        = 1'b1;
                  w_stall      = 1'b1;
                  w_state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Requests are ignored here. The core holds its inputs, so the
            // next request is seen in the following IDLE cycle.
            w_stall = !mem_ready_i;
            if (mem_ready_i) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Load lane select, using the offset and size latched at request time
   always_comb begin
      case (r_off)
         2'd0:    w_byte = mem_rd_i[7:0];
         2'd1:    w_byte = mem_rd_i[15:8];
         2'd2:    w_byte = mem_rd_i[23:16];
         default: w_byte = mem_rd_i[31:24];
      endcase
      w_half = r_off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      case (r_size)
         3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_val = {24'd0, w_byte};
         3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_val = {16'd0, w_half};
         default: w_load_val = mem_rd_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_size  <= 3'd0;
         r_off   <= 2'd0;
         r_we    <= 1'b0;
         r_rd    <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (w_req) begin
            r_size <= core_size_i;
            r_off  <= core_addr_i[1:0];
            r_we   <= core_we_i;
         end
         if ((r_state == ST_WAIT) && mem_ready_i && !r_we) begin
            r_rd <= w_load_val;
         end
      end
   end

   // Outputs are gated by rst_ni so that they stay at zero while reset is
   // asserted, even if core_req_i is high.
   assign mem_req_o    = rst_ni & w_req;
   assign mem_we_o     = rst_ni & w_req & core_we_i;
   assign mem_be_o     = (rst_ni & w_req) ? w_be : 4'b0000;
   assign mem_addr_o   = core_addr_i;
   assign mem_wd_o     = w_wd;
   assign core_stall_o = rst_ni & w_stall;
   assign misalign_o   = rst_ni & w_mis_flag;
   // A load shows its result in the WAIT cycle, and the result is held after.
   assign core_rd_o    = ((r_state == ST_WAIT) && !r_we) ? w_load_val : r_rd;

endmodule

// File: tb/tb_riscv_lsu.sv
// -----------------------------------------------------------------------------
// tb_riscv_lsu -- self-checking bench for riscv_lsu.
// Directed table of vectors, hand-written reset/misalign sequences, then random
// accesses checked against a behavioural model. Honours LSU_MISALIGN_EN.
// -----------------------------------------------------------------------------
module tb_riscv_lsu;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        misalign_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   always #5 clk_i = ~clk_i;

   riscv_lsu dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
      .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
      .core_stall_o(core_stall_o), .misalign_o(misalign_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
      .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] addr);
      int off = int'(addr % 4);
      if (size % 4 == 0) return 4'(1 << off);
      if (size % 4 == 1) return (off >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
      if (size % 4 == 0) return (wd & 32'hFF) * 32'h01010101;
      if (size % 4 == 1) return (wd & 32'hFFFF) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] model_rd(input logic [2:0] size, input logic [31:0] addr,
                                            input logic [31:0] rdata);
      int off = int'(addr % 4);
      logic [31:0] v;
      if (size % 4 == 0) begin
         v = (rdata >> (8 * off)) & 32'hFF;
         if (size < 4 && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else if (size % 4 == 1) begin
         v = (rdata >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
         if (size < 4 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic bit model_mis(input logic [2:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_EN
      if (size % 4 == 0) return 1'b0;
      if (size % 4 == 1) return (addr % 2) != 0;
      return (addr % 4) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // One complete access: request cycle, 'waits' not-ready cycles, final WAIT.
   // core_req_i stays high through WAIT to show that it is ignored there.
   task automatic access(input string tag, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int waits,
                         input logic [3:0] e_be, input logic [31:0] e_wd,
                         input logic [31:0] e_rd);
      @(posedge clk_i); #1;
      core_req_i = 1'b1; core_we_i = we; core_size_i = size;
      core_addr_i = addr; core_wd_i = wd; mem_ready_i = 1'b1; mem_rd_i = $urandom;
      @(negedge clk_i);
      chk({tag, " req"},   32'(mem_req_o), 32'd1);
      chk({tag, " stall"}, 32'(core_stall_o), 32'd1);
      chk({tag, " we"},    32'(mem_we_o), 32'(we));
      chk({tag, " be"},    32'(mem_be_o), 32'(e_be));
      chk({tag, " wd"},    mem_wd_o, e_wd);
      chk({tag, " addr"},  mem_addr_o, addr);
      chk({tag, " mis"},   32'(misalign_o), 32'd0);
      chk({tag, " rdhold"}, core_rd_o, last_rd);
      @(posedge clk_i); #1;
      mem_rd_i = rdata;
      mem_ready_i = (waits == 0);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk_i);
         chk({tag, " wstall"}, 32'(core_stall_o), 32'd1);
         chk({tag, " wreq"},   32'(mem_req_o), 32'd0);
         @(posedge clk_i); #1;
         if (i == waits - 1) mem_ready_i = 1'b1;
      end
      @(negedge clk_i);
      chk({tag, " rel"},  32'(core_stall_o), 32'd0);
      chk({tag, " req2"}, 32'(mem_req_o), 32'd0);
      if (!we) last_rd = e_rd;
      chk({tag, " rd"}, core_rd_o, last_rd);
      $display("%s we=%0d size=%0d addr=%08h be=%h wd=%08h rd=%08h", tag, we, size, addr,
               e_be, e_wd, core_rd_o);
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      mem_rd_i = $urandom;
      @(negedge clk_i);
      chk({tag, " idle req"},   32'(mem_req_o), 32'd0);
      chk({tag, " idle stall"}, 32'(core_stall_o), 32'd0);
      chk({tag, " idle rd"},    core_rd_o, last_rd);
   endtask

   task automatic misaligned(input string tag, input logic we, input logic [2:0] size,
                             input logic [31:0] addr);
      @(posedge clk_i); #1;
      core_req_i = 1'b1; core_we_i = we; core_size_i = size; core_addr_i = addr;
      core_wd_i = $urandom;
      @(negedge clk_i);
      chk({tag, " mis"},   32'(misalign_o), 32'd1);
      chk({tag, " req"},   32'(mem_req_o), 32'd0);
      chk({tag, " stall"}, 32'(core_stall_o), 32'd0);
      chk({tag, " we"},    32'(mem_we_o), 32'd0);
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      @(negedge clk_i);
      chk({tag, " mis off"}, 32'(misalign_o), 32'd0);
      chk({tag, " idle"},    32'(core_stall_o), 32'd0);
      $display("%s misaligned size=%0d addr=%08h", tag, size, addr);
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          waits;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] rd;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{"SW",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF, 32'h0};
      tbl[1] = '{"SB",  1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 4'h8, 32'hA5A5A5A5, 32'h0};
      tbl[2] = '{"LB",  1'b0, 3'b000, 32'h102, 32'h0,        32'h12F03456, 0, 4'h4, 32'h0,        32'hFFFFFFF0};
      tbl[3] = '{"LBU", 1'b0, 3'b100, 32'h102, 32'h0,        32'h12F03456, 0, 4'h4, 32'h0,        32'h000000F0};
      tbl[4] = '{"LH",  1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 3, 4'hC, 32'h0,        32'hFFFF8001};
      tbl[5] = '{"SH",  1'b1, 3'b001, 32'h002, 32'h1234BEEF, 32'h0,        0, 4'hC, 32'hBEEFBEEF, 32'h0};

      // Reset, with a request pending on the core side: every output stays low.
      last_rd = 32'd0;
      rst_ni = 1'b0; core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b010;
      core_addr_i = 32'h100; core_wd_i = 32'h55; mem_rd_i = 32'h0; mem_ready_i = 1'b1;
      #12;
      chk("rst req",   32'(mem_req_o), 32'd0);
      chk("rst stall", 32'(core_stall_o), 32'd0);
      chk("rst we",    32'(mem_we_o), 32'd0);
      chk("rst be",    32'(mem_be_o), 32'd0);
      chk("rst mis",   32'(misalign_o), 32'd0);
      chk("rst rd",    core_rd_o, 32'd0);
      @(posedge clk_i); #1;
      core_req_i = 1'b0;
      rst_ni = 1'b1;
      idle_cycle("post-rst");

      // Directed table. The accesses run back to back, with no idle cycle
      // between them.
      for (int i = 0; i < 6; i++) begin
         access(tbl[i].name, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wd,
                tbl[i].rdata, tbl[i].waits, tbl[i].be, tbl[i].mwd, tbl[i].rd);
      end
      idle_cycle("tbl");

      // Misaligned LW at 0x101
`ifdef LSU_MISALIGN_EN
      misaligned("LWmis", 1'b0, 3'b010, 32'h101);
`else
      access("LWmis", 1'b0, 3'b010, 32'h101, 32'h0, 32'hA1B2C3D4, 0, 4'hF, 32'h0, 32'hA1B2C3D4);
      idle_cycle("LWmis");
`endif

      // Reset pulse during WAIT aborts the access.
      @(posedge clk_i); #1;
      core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h200;
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0; mem_rd_i = 32'hCAFEF00D;
      @(negedge clk_i);
      chk("rstwait pre stall", 32'(core_stall_o), 32'd1);
      #1 rst_ni = 1'b0;
      #1;
      chk("rstwait stall", 32'(core_stall_o), 32'd0);
      chk("rstwait rd",    core_rd_o, 32'd0);
      chk("rstwait req",   32'(mem_req_o), 32'd0);
      last_rd = 32'd0;
      @(posedge clk_i); #1;
      rst_ni = 1'b1; core_req_i = 1'b0; mem_ready_i = 1'b1;
      @(negedge clk_i);
      chk("rstwait after stall", 32'(core_stall_o), 32'd0);
      $display("rstwait abort done rd=%08h", core_rd_o);
      access("LWpost", 1'b0, 3'b010, 32'h204, 32'h0, 32'h13572468, 0, 4'hF, 32'h0, 32'h13572468);
      idle_cycle("LWpost");

      // Random accesses checked against the model
      for (int n = 0; n < 60; n++) begin
         logic [2:0]  sz;
         logic [31:0] ad, wd, rdv;
         logic        we;
         int          k;
         k = int'($urandom_range(0, 4));
         sz = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : (k == 2) ? 3'b010 :
              (k == 3) ? 3'b100 : 3'b101;
         we = $urandom_range(0, 1) == 1;
         if (we && sz[2]) sz = {1'b0, sz[1:0]};
         ad = $urandom; wd = $urandom; rdv = $urandom;
         if (model_mis(sz, ad)) begin
            misaligned("RND", we, sz, ad);
         end else begin
            access("RND", we, sz, ad, wd, rdv, int'($urandom_range(0, 2)),
                   model_be(sz, ad), model_wd(sz, wd), model_rd(sz, ad, rdv));
            if ($urandom_range(0, 1) == 1) idle_cycle("RND");
         end
      end
      idle_cycle("end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
